// File: rtl/mini_dmem_responder.sv
// mini_dmem_responder: slave end of the core load/store port.
// Accepts one request per handshake, answers after LAT wait cycles.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_we               1 = write, 0 = read
//   req_addr, req_wdata  word address and write data
//   rsp_valid/rsp_ready  response handshake (valid held until ready)
//   rsp_rdata            read data, write echo, or 0 on error
//   rsp_err              address was >= DEPTH

`default_nettype none

module mini_dmem_responder #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ready_q;
  logic              valid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  logic [ADDR_W:0] depth_c;
  logic            in_range;
  logic            accept;

  assign depth_c  = (ADDR_W+1)'(DEPTH);
  assign in_range = {1'b0, req_addr} < depth_c;
  assign accept   = req_valid & ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (in_range) begin
              err_q <= 1'b0;
              if (req_we) begin
                mem_q[req_addr] <= req_wdata;
                rdata_q         <= req_wdata;
              end else begin
                rdata_q <= mem_q[req_addr];
              end
            end else begin
              rdata_q <= '0;
              err_q   <= 1'b1;
            end
            cnt_q   <= CNT_W'(LAT);
            ready_q <= 1'b0;
            if (LAT == 0) begin
              state_q <= RESP;
              valid_q <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= RESP;
            valid_q <= 1'b1;
          end
        end
        RESP: begin
          // ready_q comes back from state only, never from rsp_ready.
          if (rsp_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mini_dmem_responder.sv
// tb_mini_dmem_responder: scoreboard bench for mini_dmem_responder.
// Three instances: default, DEPTH=12, LAT=0.

`timescale 1ns/1ps

module tb_mini_dmem_responder;

  localparam int N = 3;
  localparam int LATV [N] = '{2, 2, 0};

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst       [N];
  logic       req_valid [N];
  logic       req_ready [N];
  logic       req_we    [N];
  logic [3:0] req_addr  [N];
  logic [7:0] req_wdata [N];
  logic       rsp_valid [N];
  logic       rsp_ready [N];
  logic [7:0] rsp_rdata [N];
  logic       rsp_err   [N];

  exp_t sb [N][$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic       pv [N];
  logic [7:0] hd [N];
  logic       he [N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mini_dmem_responder #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .LAT(2)) u0 (
    .clk(clk), .rst(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  mini_dmem_responder #(.ADDR_W(4), .DATA_W(8), .DEPTH(12), .LAT(2)) u1 (
    .clk(clk), .rst(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  mini_dmem_responder #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .LAT(0)) u2 (
    .clk(clk), .rst(rst[2]),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
  );

  task automatic chk(input string nm, input int i,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)",
               nm, i, act, exp, $time);
    end
  endtask

  // Monitor: compares each response against the scoreboard head.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rsp_valid[i] === 1'b1) begin
        chk("req_ready_busy", i, 32'(req_ready[i]), 32'd0);
        if (!pv[i]) begin
          if (sb[i].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_rsp dut%0d: got rsp_valid=1 expected none",
                     i);
          end else begin
            chk("rsp_latency", i, 32'(cyc), 32'(sb[i][0].acc + LATV[i]));
            chk("rsp_rdata", i, 32'(rsp_rdata[i]), 32'(sb[i][0].rdata));
            chk("rsp_err", i, 32'(rsp_err[i]), 32'(sb[i][0].err));
          end
        end else begin
          chk("rdata_stable", i, 32'(rsp_rdata[i]), 32'(hd[i]));
          chk("err_stable", i, 32'(rsp_err[i]), 32'(he[i]));
        end
        if (rsp_ready[i] && sb[i].size() > 0) void'(sb[i].pop_front());
      end
      pv[i] <= (rsp_valid[i] === 1'b1);
      hd[i] <= rsp_rdata[i];
      he[i] <= rsp_err[i];
    end
  end

  // Called at posedge+1; returns with the request accepted and dropped.
  task automatic issue(input int i, input logic we, input logic [3:0] a,
                       input logic [7:0] wd, input logic [7:0] er,
                       input logic ee, output int acc);
    int n;
    exp_t e;
    n = 0;
    req_we[i]    = we;
    req_addr[i]  = a;
    req_wdata[i] = wd;
    req_valid[i] = 1'b1;
    while (!req_ready[i] && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!req_ready[i]) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout dut%0d: got req_ready=0 expected 1", i);
      req_valid[i] = 1'b0;
      acc = -1;
      return;
    end
    acc   = cyc + 1;
    e.rdata = er;
    e.err   = ee;
    e.acc   = acc;
    sb[i].push_back(e);
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    while ((sb[i].size() != 0 || rsp_valid[i]) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", i, 32'(sb[i].size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int a0, a1, a2, n;
    for (int i = 0; i < N; i++) begin
      rst[i]       = 1'b1;
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
      rsp_ready[i] = 1'b1;
      pv[i]        = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) rst[i] = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("rst_req_ready", i, 32'(req_ready[i]), 32'd1);
      chk("rst_rsp_valid", i, 32'(rsp_valid[i]), 32'd0);
      chk("rst_rsp_rdata", i, 32'(rsp_rdata[i]), 32'd0);
      chk("rst_rsp_err", i, 32'(rsp_err[i]), 32'd0);
    end

    // Cleared RAM reads back zero everywhere.
    for (int a = 0; a < 16; a++) issue(0, 1'b0, 4'(a), 8'h00, 8'h00, 1'b0, a0);
    drain(0);

    // Write then read back.
    issue(0, 1'b1, 4'd3, 8'h08, 8'h08, 1'b0, a0);
    issue(0, 1'b0, 4'd3, 8'h00, 8'h08, 1'b0, a0);
    drain(0);

    // Backpressure on a read of 8'h5A.
    issue(0, 1'b1, 4'd5, 8'h5A, 8'h5A, 1'b0, a0);
    drain(0);
    rsp_ready[0] = 1'b0;
    issue(0, 1'b0, 4'd5, 8'h00, 8'h5A, 1'b0, a0);
    n = 0;
    while (!rsp_valid[0] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("bp_valid_held", 0, 32'(rsp_valid[0]), 32'd1);
    chk("bp_ready_low", 0, 32'(req_ready[0]), 32'd0);
    chk("bp_pending", 0, 32'(sb[0].size()), 32'd1);
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_valid_clr", 0, 32'(rsp_valid[0]), 32'd0);
    chk("bp_ready_back", 0, 32'(req_ready[0]), 32'd1);
    chk("bp_done", 0, 32'(sb[0].size()), 32'd0);

    // DEPTH=12: out-of-range accesses do not alias.
    issue(1, 1'b1, 4'd1,  8'h44, 8'h44, 1'b0, a0);
    issue(1, 1'b1, 4'd13, 8'hFF, 8'h00, 1'b1, a0);
    issue(1, 1'b0, 4'd13, 8'h00, 8'h00, 1'b1, a0);
    issue(1, 1'b0, 4'd1,  8'h00, 8'h44, 1'b0, a0);
    issue(1, 1'b1, 4'd11, 8'h77, 8'h77, 1'b0, a0);
    issue(1, 1'b0, 4'd11, 8'h00, 8'h77, 1'b0, a0);
    issue(1, 1'b1, 4'd12, 8'h99, 8'h00, 1'b1, a0);
    issue(1, 1'b0, 4'd15, 8'h00, 8'h00, 1'b1, a0);
    issue(1, 1'b0, 4'd0,  8'h00, 8'h00, 1'b0, a0);
    drain(1);

    // LAT=0: one accept every two cycles.
    issue(2, 1'b1, 4'd4, 8'hC3, 8'hC3, 1'b0, a0);
    issue(2, 1'b0, 4'd4, 8'h00, 8'hC3, 1'b0, a1);
    issue(2, 1'b0, 4'd15, 8'h00, 8'h00, 1'b0, a2);
    chk("lat0_spacing1", 2, 32'(a1 - a0), 32'd2);
    chk("lat0_spacing2", 2, 32'(a2 - a1), 32'd2);
    drain(2);

    // Reset during WAIT discards the write.
    issue(0, 1'b1, 4'd7, 8'h33, 8'h33, 1'b0, a0);
    rst[0] = 1'b1;
    sb[0].delete();
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    chk("mid_rst_ready", 0, 32'(req_ready[0]), 32'd1);
    chk("mid_rst_valid", 0, 32'(rsp_valid[0]), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("mid_rst_quiet", 0, 32'(rsp_valid[0]), 32'd0);
    issue(0, 1'b0, 4'd7, 8'h00, 8'h00, 1'b0, a0);
    issue(0, 1'b0, 4'd3, 8'h00, 8'h00, 1'b0, a0);
    drain(0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
